spiker_result_capture: RTL and testbench

Double-buffered capture stage between the spiker core's wide spike-result vector and the register-file result words. On `sample_i` the `DATA_WIDTH`-bit vector is sliced into `WIDTH`-bit words. Each snapshot either goes straight to the visible bank or is parked in a shadow bank until software acknowledges the previous one. The block adds an overwrite/hold mode, overflow detection, sample and drop counters, and an optional commit timestamp.

---
 rtl/spiker_result_capture.sv | 211 +++++++++++++++++++++
 tb/tb_spiker_result_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spiker_result_capture.sv
// -----------------------------------------------------------------------------
// spiker_result_capture
//   Double-buffered capture of the spiker core's result vector into
//   WIDTH-bit register words. A snapshot is loaded into the visible bank
//   directly or parked in a shadow bank until the visible one is acknowledged.
//   mode_i selects overwrite (0) or hold (1) behaviour. The block also tracks
//   overflow, counts samples (wrapping) and drops (saturating), and optionally
//   timestamps each commit.
//
// Optional feature macro: SPIKER_CAPTURE_TS_EN (adds TS_W, ts_o, cycle counter)
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   data_out_i   : DATA_WIDTH result vector, sampled while sample_i is high
//   sample_i     : one-cycle capture strobe
//   ack_i        : software acknowledge of the visible bank
//   clear_i      : synchronous clear, highest priority
//   mode_i       : 0 = overwrite, 1 = hold
//   result_o     : visible bank, word i at [i*WIDTH +: WIDTH]
//   result_de_o  : pulses in the cycle after result_o is loaded
//   valid_o      : visible bank holds an unacknowledged snapshot
//   pending_o    : shadow bank holds a snapshot
//   overflow_o   : sticky, a snapshot was dropped
//   sample_cnt_o : accepted samples, wrapping
//   drop_cnt_o   : dropped snapshots, saturating
//   ts_o         : timestamp of the snapshot in result_o (macro only)
// -----------------------------------------------------------------------------
module spiker_result_capture #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DATA_WIDTH = 800,
  parameter int unsigned CNT_W      = 16
`ifdef SPIKER_CAPTURE_TS_EN
  ,
  parameter int unsigned TS_W       = 32
`endif
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic [DATA_WIDTH-1:0]                            data_out_i,
  input  logic                                             sample_i,
  input  logic                                             ack_i,
  input  logic                                             clear_i,
  input  logic                                             mode_i,
  output logic [((DATA_WIDTH+WIDTH-1)/WIDTH)*WIDTH-1:0]    result_o,
  output logic                                             result_de_o,
  output logic                                             valid_o,
  output logic                                             pending_o,
  output logic                                             overflow_o,
  output logic [CNT_W-1:0]                                 sample_cnt_o,
  output logic [CNT_W-1:0]                                 drop_cnt_o
`ifdef SPIKER_CAPTURE_TS_EN
  ,
  output logic [TS_W-1:0]                                  ts_o
`endif
);

  localparam int unsigned N_REG  = (DATA_WIDTH + WIDTH - 1) / WIDTH;
  localparam int unsigned BANK_W = N_REG * WIDTH;

  typedef enum logic [1:0] {
    EMPTY        = 2'd0,
    FULL         = 2'd1,
    FULL_PENDING = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   data_pad;
  logic [BANK_W-1:0]   result_q;
  logic [BANK_W-1:0]   shadow_q;
  logic                result_de_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    sample_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic                load_direct;   // result <= incoming data
  logic                load_commit;   // result <= shadow
  logic                shadow_load;   // shadow <= incoming data
  logic                drop;          // an unread shadow snapshot is overwritten

  // Bits of the top word beyond DATA_WIDTH read as zero.
  always_comb begin
    data_pad                   = '0;
    data_pad[DATA_WIDTH-1:0]   = data_out_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_direct = 1'b0;
    load_commit = 1'b0;
    shadow_load = 1'b0;
    drop        = 1'b0;
    if (mode_i) begin
      case (state_q)
        EMPTY: begin
          if (sample_i) begin
            load_direct = 1'b1;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (sample_i && ack_i) begin
            load_direct = 1'b1;
          end else if (sample_i) begin
            shadow_load = 1'b1;
            state_d     = FULL_PENDING;
          end else if (ack_i) begin
            state_d     = EMPTY;
          end
        end
        FULL_PENDING: begin
          if (ack_i) begin
            // Shadow moves up; a simultaneous sample refills the shadow.
            load_commit = 1'b1;
            shadow_load = sample_i;
            state_d     = sample_i ? FULL_PENDING : FULL;
          end else if (sample_i) begin
            shadow_load = 1'b1;
            drop        = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      // Overwrite mode: a fresh sample always wins; a leftover shadow from
      // hold mode is committed once and then the shadow stays unused.
      if (sample_i) begin
        load_direct = 1'b1;
        state_d     = FULL;
      end else if (state_q == FULL_PENDING) begin
        load_commit = 1'b1;
        state_d     = FULL;
      end else if (state_q == FULL && ack_i) begin
        state_d     = EMPTY;
      end
    end
    if (clear_i) begin
      state_d     = EMPTY;
      load_direct = 1'b0;
      load_commit = 1'b0;
      shadow_load = 1'b0;
      drop        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q     <= '0;
      shadow_q     <= '0;
      result_de_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else if (clear_i) begin
      result_q     <= '0;
      shadow_q     <= '0;
      result_de_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (load_direct)      result_q <= data_pad;
      else if (load_commit) result_q <= shadow_q;
      if (shadow_load)      shadow_q <= data_pad;
      result_de_q <= load_direct | load_commit;
      if (drop)             overflow_q <= 1'b1;
      if (sample_i)         sample_cnt_q <= sample_cnt_q + 1'b1;
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

`ifdef SPIKER_CAPTURE_TS_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] shadow_ts_q;

  // Timestamp travels with its snapshot through the same load paths.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_cnt_q    <= '0;
      ts_q        <= '0;
      shadow_ts_q <= '0;
    end else if (clear_i) begin
      ts_cnt_q    <= '0;
      ts_q        <= '0;
      shadow_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (load_direct)      ts_q <= ts_cnt_q;
      else if (load_commit) ts_q <= shadow_ts_q;
      if (shadow_load)      shadow_ts_q <= ts_cnt_q;
    end
  end

  assign ts_o = ts_q;
`endif

  assign result_o     = result_q;
  assign result_de_o  = result_de_q;
  assign valid_o      = (state_q != EMPTY);
  assign pending_o    = (state_q == FULL_PENDING);
  assign overflow_o   = overflow_q;
  assign sample_cnt_o = sample_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_spiker_result_capture.sv
module tb_spiker_result_capture;

  localparam int W  = 32;
  localparam int DW = 800;
  localparam int CW = 4;   // small counters so wrap/saturation are reachable

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] data_out_i = '0;
  logic          sample_i = 1'b0;
  logic          ack_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          mode_i = 1'b1;
  logic [DW-1:0] result_o;
  logic          result_de_o, valid_o, pending_o, overflow_o;
  logic [CW-1:0] sample_cnt_o, drop_cnt_o;
`ifdef SPIKER_CAPTURE_TS_EN
  logic [31:0]   ts_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  spiker_result_capture #(.WIDTH(W), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_out_i(data_out_i),
    .sample_i(sample_i), .ack_i(ack_i), .clear_i(clear_i), .mode_i(mode_i),
    .result_o(result_o), .result_de_o(result_de_o), .valid_o(valid_o),
    .pending_o(pending_o), .overflow_o(overflow_o),
    .sample_cnt_o(sample_cnt_o), .drop_cnt_o(drop_cnt_o)
`ifdef SPIKER_CAPTURE_TS_EN
    , .ts_o(ts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Word i of a tagged vector is {tag, i}.
  function automatic logic [DW-1:0] mk(input logic [15:0] tag);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / W; i++) v[i*W +: W] = {tag, 16'(i)};
    return v;
  endfunction

  task automatic step(input logic s, input logic a, input logic c, input logic [DW-1:0] d);
    sample_i = s; ack_i = a; clear_i = c; data_out_i = d;
    @(posedge clk_i); #1;
    sample_i = 1'b0; ack_i = 1'b0; clear_i = 1'b0;
    $display("[TB] t=%0t mode=%b sample=%b ack=%b clear=%b -> valid=%b pending=%b de=%b ovf=%b scnt=%0d dcnt=%0d",
             $time, mode_i, s, a, c, valid_o, pending_o, result_de_o, overflow_o, sample_cnt_o, drop_cnt_o);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; #1;
    tests_run++; if (result_o !== '0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result_o); end
    tests_run++; if ({valid_o, pending_o, overflow_o, result_de_o} !== 4'b0) begin tests_failed++;
      $display("FAIL reset_flags got %b want 0000", {valid_o, pending_o, overflow_o, result_de_o}); end
    tests_run++; if ({sample_cnt_o, drop_cnt_o} !== '0) begin tests_failed++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", sample_cnt_o, drop_cnt_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_first_sample;
    logic [DW-1:0] v;
    v = '0; v[0] = 1'b1; v[24*W +: W] = 32'hA5;
    mode_i = 1'b1;
    step(1, 0, 0, v);
    tests_run++; if (result_o[0 +: W] !== 32'h1 || result_o[24*W +: W] !== 32'hA5) begin tests_failed++;
      $display("FAIL first_words got %h/%h want 1/a5", result_o[0 +: W], result_o[24*W +: W]); end
    tests_run++; if ({valid_o, result_de_o} !== 2'b11) begin tests_failed++;
      $display("FAIL first_valid_de got %b want 11", {valid_o, result_de_o}); end
    tests_run++; if (sample_cnt_o !== 4'd1) begin tests_failed++;
      $display("FAIL first_scnt got %0d want 1", sample_cnt_o); end
    step(0, 0, 0, '0);
    tests_run++; if (result_de_o !== 1'b0) begin tests_failed++;
      $display("FAIL first_de_single got %b want 0", result_de_o); end
    step(0, 1, 0, '0);
    tests_run++; if (valid_o !== 1'b0 || result_o[24*W +: W] !== 32'hA5) begin tests_failed++;
      $display("FAIL first_ack got valid=%b w24=%h want 0/a5", valid_o, result_o[24*W +: W]); end
  endtask

  task automatic test_hold_overflow;
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'hA));
    step(1, 0, 0, mk(16'hB));
    step(1, 0, 0, mk(16'hC));
    tests_run++; if (result_o !== mk(16'hA)) begin tests_failed++; $display("FAIL hold_result got %h want %h", result_o, mk(16'hA)); end
    tests_run++; if ({pending_o, overflow_o, drop_cnt_o, sample_cnt_o} !== {1'b1, 1'b1, 4'd1, 4'd3}) begin tests_failed++;
      $display("FAIL hold_flags got p=%b o=%b d=%0d s=%0d want 1 1 1 3", pending_o, overflow_o, drop_cnt_o, sample_cnt_o); end
    step(0, 1, 0, '0);
    tests_run++; if (result_o !== mk(16'hC) || pending_o !== 1'b0 || valid_o !== 1'b1 || result_de_o !== 1'b1) begin tests_failed++;
      $display("FAIL hold_ack got %h p=%b v=%b de=%b want %h 0 1 1", result_o, pending_o, valid_o, result_de_o, mk(16'hC)); end
  endtask

  task automatic test_ack_and_sample;
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'h11));
    step(1, 0, 0, mk(16'h22));
    step(1, 1, 0, mk(16'hD));
    tests_run++; if (result_o !== mk(16'h22) || pending_o !== 1'b1 || overflow_o !== 1'b0 || drop_cnt_o !== 4'd0) begin tests_failed++;
      $display("FAIL acksamp got %h p=%b o=%b d=%0d want %h 1 0 0", result_o, pending_o, overflow_o, drop_cnt_o, mk(16'h22)); end
    step(0, 1, 0, '0);
    tests_run++; if (result_o !== mk(16'hD) || pending_o !== 1'b0) begin tests_failed++;
      $display("FAIL acksamp_shadow got %h p=%b want %h 0", result_o, pending_o, mk(16'hD)); end
  endtask

  task automatic test_overwrite;
    mode_i = 1'b0;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'hA));
    step(1, 0, 0, mk(16'hB));
    tests_run++; if (result_o !== mk(16'hB) || pending_o !== 1'b0 || drop_cnt_o !== 4'd0 || sample_cnt_o !== 4'd2) begin tests_failed++;
      $display("FAIL ovw got %h p=%b d=%0d s=%0d want %h 0 0 2", result_o, pending_o, drop_cnt_o, sample_cnt_o, mk(16'hB)); end
    step(0, 1, 0, '0);
    tests_run++; if (valid_o !== 1'b0 || result_o !== mk(16'hB)) begin tests_failed++;
      $display("FAIL ovw_ack got v=%b %h want 0 %h", valid_o, result_o, mk(16'hB)); end
  endtask

  task automatic test_mode_switch;
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'h31));
    step(1, 0, 0, mk(16'h32));
    mode_i = 1'b0;
    step(0, 0, 0, '0);
    tests_run++; if (result_o !== mk(16'h32) || {valid_o, pending_o, result_de_o} !== 3'b101) begin tests_failed++;
      $display("FAIL switch_commit got %h vpd=%b want %h 101", result_o, {valid_o, pending_o, result_de_o}, mk(16'h32)); end
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'h41));
    step(1, 0, 0, mk(16'h42));
    mode_i = 1'b0;
    step(1, 0, 0, mk(16'h43));
    tests_run++; if (result_o !== mk(16'h43) || pending_o !== 1'b0 || drop_cnt_o !== 4'd0 || overflow_o !== 1'b0) begin tests_failed++;
      $display("FAIL switch_sample got %h p=%b d=%0d o=%b want %h 0 0 0", result_o, pending_o, drop_cnt_o, overflow_o, mk(16'h43)); end
  endtask

  task automatic test_clear_priority;
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    step(1, 0, 0, mk(16'h51));
    step(1, 0, 0, mk(16'h52));
    step(1, 0, 0, mk(16'h53));
    step(1, 1, 1, mk(16'h54));
    tests_run++; if (result_o !== '0 || {valid_o, pending_o, overflow_o, result_de_o} !== 4'b0 || sample_cnt_o !== 4'd0 || drop_cnt_o !== 4'd0) begin tests_failed++;
      $display("FAIL clear got r=%h vpod=%b s=%0d d=%0d want 0", result_o, {valid_o, pending_o, overflow_o, result_de_o}, sample_cnt_o, drop_cnt_o); end
  endtask

  task automatic test_async_reset;
    mode_i = 1'b1;
    step(1, 0, 0, mk(16'h61));
    step(1, 0, 0, mk(16'h62));
    #3 rst_ni = 1'b0;
    #1;
    tests_run++; if (result_o !== '0 || {valid_o, pending_o} !== 2'b00 || sample_cnt_o !== 4'd0) begin tests_failed++;
      $display("FAIL async_reset got r=%h vp=%b s=%0d want 0", result_o, {valid_o, pending_o}, sample_cnt_o); end
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_counter_limits;
    mode_i = 1'b1;
    step(0, 0, 1, '0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, mk(16'(16'h100 + i)));
    // 1 direct + 1 shadow + 18 drops: drop saturates at 15, samples wrap 20 mod 16.
    tests_run++; if (drop_cnt_o !== 4'd15 || sample_cnt_o !== 4'd4) begin tests_failed++;
      $display("FAIL cnt_limits got d=%0d s=%0d want 15 4", drop_cnt_o, sample_cnt_o); end
    tests_run++; if (result_o !== mk(16'h100)) begin tests_failed++;
      $display("FAIL cnt_limits_result got %h want %h", result_o, mk(16'h100)); end
  endtask

`ifdef SPIKER_CAPTURE_TS_EN
  task automatic test_timestamp;
    mode_i = 1'b1;
    step(0, 0, 1, '0);                       // counter 0 after this edge
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0);
    step(1, 0, 0, mk(16'h71));               // captures 10
    tests_run++; if (ts_o !== 32'd10) begin tests_failed++; $display("FAIL ts_first got %0d want 10", ts_o); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
    step(1, 0, 0, mk(16'h72));               // captures 15 into shadow
    tests_run++; if (ts_o !== 32'd10) begin tests_failed++; $display("FAIL ts_held got %0d want 10", ts_o); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    tests_run++; if (ts_o !== 32'd15) begin tests_failed++; $display("FAIL ts_ack got %0d want 15", ts_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_sample();
    test_hold_overflow();
    test_ack_and_sample();
    test_overwrite();
    test_mode_switch();
    test_clear_priority();
    test_async_reset();
    test_counter_limits();
`ifdef SPIKER_CAPTURE_TS_EN
    test_timestamp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
